gp_cmd_scheduler: RTL

//   Queues draw commands from two requesters (req0: game controller, req1: score/note renderer)
//   and issues them one at a time to graphics_processor over its en/finish handshake.

---
 rtl/gp_cmd_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gp_cmd_scheduler.sv
// gp_cmd_scheduler: round-robin merge of two command streams into a FIFO,
// drained one command at a time into graphics_processor via en/finish.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   req0_valid/cmd/ready        requester 0 (game controller) handshake
//   req1_valid/cmd/ready        requester 1 (score/note renderer) handshake
//   gp_finish                   graphics_processor done pulse
//   gp_en                       one-cycle start pulse to graphics_processor
//   gp_opcode..gp_arg           issued command fields, held until next load
//   busy                        sequencer in ISSUE or WAIT
//   level                       FIFO occupancy 0..DEPTH
module gp_cmd_scheduler #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [50:0]       req0_cmd,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [50:0]       req1_cmd,
  output logic              req1_ready,
  input  logic              gp_finish,
  output logic              gp_en,
  output logic              gp_opcode,
  output logic [9:0]        gp_tl_x,
  output logic [8:0]        gp_tl_y,
  output logic [9:0]        gp_br_x,
  output logic [8:0]        gp_br_y,
  output logic [11:0]       gp_arg,
  output logic              busy,
  output logic [ADDR_W:0]   level
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  state_t state, state_nx;

  logic [50:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              last_grant;
  logic [50:0]       cur;

  logic full;
  logic grant0;
  logic grant1;
  logic push0;
  logic push1;
  logic push;
  logic load;
  logic [50:0] push_cmd;

  // last_grant: 1 = req1 won last, so req0 wins the next tie.
  assign full   = (count == FULL_LVL);
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = grant0 & ~full & ~rst;
  assign req1_ready = grant1 & ~full & ~rst;

  assign push0    = req0_valid & req0_ready;
  assign push1    = req1_valid & req1_ready;
  assign push     = push0 | push1;
  assign push_cmd = push0 ? req0_cmd : req1_cmd;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_cmd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= push1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cur   <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        cur <= mem[rd_ptr];
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != '0) begin
          load     = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (gp_finish) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign gp_en     = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);
  assign level     = count;
  assign gp_opcode = cur[50];
  assign gp_tl_x   = cur[49:40];
  assign gp_tl_y   = cur[39:31];
  assign gp_br_x   = cur[30:21];
  assign gp_br_y   = cur[20:12];
  assign gp_arg    = cur[11:0];

endmodule
